// File: rtl/spi_pkg.sv
// Shared types for the SPI-RAM slave: FSM state encoding and the 2-bit command field values.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-in/serial-out MISO shifter, MSB first; first bit visible the cycle after i_load.
// o_last marks the final bit cycle; i_abort drops any transfer in progress and forces the output low.
module spi_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_serial,
    output logic                  o_busy,
    output logic                  o_last
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= CW'(DATA_WIDTH);
        end else if (r_cnt != '0) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    assign o_busy   = (r_cnt != '0);
    assign o_last   = (r_cnt == CW'(1));
    assign o_serial = o_busy & r_shift[DATA_WIDTH-1];

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front end: deserialises {cmd,payload} frames back-to-back under one SS_n and
// returns RAM read data on MISO; early SS_n deassertion aborts the frame with a frame_err pulse.
module spi_slave_burst
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  frame_err
);
    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int CNT_W   = $clog2(FRAME_W);

    spi_state_e         r_state;
    spi_state_e         w_state_next;
    logic [FRAME_W-2:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_rd_addr_seen;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;

    logic w_sample, w_done, w_abort, w_err, w_tx_load;
    logic w_tx_busy, w_tx_last, w_tx_serial;
    logic w_last_bit;

    assign w_last_bit = (r_bit_cnt == CNT_W'(FRAME_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // r_bit_cnt == 0 inside READ_DATA means the frame is done and we are waiting for RAM data.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        w_err        = 1'b0;
        w_tx_load    = 1'b0;
        if (r_state != IDLE && SS_n) begin
            w_state_next = IDLE;
            w_abort      = 1'b1;
            w_err        = (r_bit_cnt != '0) || w_tx_busy;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!SS_n) w_state_next = CHK_CMD;
                end
                CHK_CMD: begin
                    w_sample = 1'b1;
                    if (!MOSI)               w_state_next = WRITE;
                    else if (r_rd_addr_seen) w_state_next = READ_DATA;
                    else                     w_state_next = READ_ADD;
                end
                WRITE, READ_ADD: begin
                    w_sample = 1'b1;
                    if (w_last_bit) begin
                        w_done       = 1'b1;
                        w_state_next = CHK_CMD;
                    end
                end
                READ_DATA: begin
                    if (w_tx_busy) begin
                        if (w_tx_last) w_state_next = CHK_CMD;
                    end else if (r_bit_cnt == '0) begin
                        w_tx_load = tx_valid;
                    end else begin
                        w_sample = 1'b1;
                        w_done   = w_last_bit;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_rd_addr_seen <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_rx_valid  <= w_done;
            r_frame_err <= w_err;
            if (w_abort) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift   <= {r_shift[FRAME_W-3:0], MOSI};
                r_bit_cnt <= w_done ? '0 : r_bit_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_rx_data <= {r_shift, MOSI};
                if (r_state == READ_ADD)       r_rd_addr_seen <= 1'b1;
                else if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
            end
        end
    end

    spi_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tx_load),
        .i_abort  (w_abort),
        .i_data   (tx_data),
        .o_serial (w_tx_serial),
        .o_busy   (w_tx_busy),
        .o_last   (w_tx_last)
    );

    assign MISO      = w_tx_serial;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Randomised bench for spi_slave_burst: a transaction-level model expands frames and reads
// into per-cycle stimulus plus expected outputs, replayed against the DUT.
module tb_spi_slave_burst;
    localparam int DW = 8;
    localparam int FW = DW + 2;

    logic          clk = 1'b0;
    logic          rst, SS_n, MOSI, MISO, rx_valid, tx_valid, frame_err;
    logic [FW-1:0] rx_data;
    logic [DW-1:0] tx_data;

    always #5 clk = ~clk;

    spi_slave_burst #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // per-cycle script: inputs for edge i, outputs expected just after edge i
    bit            q_ss[$], q_mosi[$], q_txv[$];
    logic [DW-1:0] q_txd[$];
    bit            e_rxv[$], e_err[$], e_miso[$];
    logic [FW-1:0] e_rxd[$];

    // transaction-level model state
    bit            m_sel, m_rd_seen, m_pend;
    logic [FW-1:0] m_rx;

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [DW-1:0] rbyte();
        return DW'($urandom);
    endfunction

    task automatic push(input bit ss, input bit mosi, input bit txv, input logic [DW-1:0] txd,
                        input bit rxv, input bit err, input bit miso);
        q_ss.push_back(ss);   q_mosi.push_back(mosi);
        q_txv.push_back(txv); q_txd.push_back(txd);
        e_rxv.push_back(rxv); e_err.push_back(err); e_miso.push_back(miso);
        e_rxd.push_back(m_rx);
    endtask

    task automatic model_reset();
        m_sel = 0; m_rd_seen = 0; m_pend = 0; m_rx = '0;
    endtask

    task automatic desel();
        push(1'b1, rbit(), rbit(), rbyte(), 0, 0, 0);
        m_sel = 0;
    endtask

    // k = number of frame bits sent (FW = complete); ss_hi raises SS_n right after a short frame
    task automatic frame(input logic [1:0] cmd, input logic [DW-1:0] pl, input int k, input bit ss_hi);
        logic [FW-1:0] f;
        bit            rd_data;
        f = {cmd, pl};
        if (!m_sel) begin
            push(1'b0, rbit(), rbit(), rbyte(), 0, 0, 0);
            m_sel = 1;
        end
        rd_data = cmd[1] && m_rd_seen;
        for (int i = 0; i < k; i++) begin
            if (i == FW - 1) m_rx = f;
            push(1'b0, f[FW-1-i], rbit(), rbyte(), i == FW - 1, 0, 0);
        end
        if (k < FW) begin
            if (ss_hi) begin
                push(1'b1, rbit(), rbit(), rbyte(), 0, k > 0, 0);
                m_sel = 0;
            end
            return;
        end
        if (cmd[1]) begin
            if (rd_data) begin
                m_rd_seen = 0;
                m_pend    = 1;
            end else begin
                m_rd_seen = 1;
            end
        end
    endtask

    // w idle wait cycles, then tx_valid with d; aj<0 aborts while waiting, aj in 1..DW aborts at T+aj
    task automatic xmit(input int w, input logic [DW-1:0] d, input int aj);
        m_pend = 0;
        for (int i = 0; i < w; i++) push(1'b0, rbit(), 1'b0, rbyte(), 0, 0, 0);
        if (aj < 0) begin
            push(1'b1, rbit(), rbit(), rbyte(), 0, 0, 0);
            m_sel = 0;
            return;
        end
        push(1'b0, rbit(), 1'b1, d, 0, 0, d[DW-1]);
        for (int j = 1; j <= DW; j++) begin
            if (aj == j) begin
                push(1'b1, rbit(), rbit(), rbyte(), 0, 1, 0);
                m_sel = 0;
                return;
            end
            push(1'b0, rbit(), rbit(), rbyte(), 0, 0, (j < DW) ? d[DW-1-j] : 1'b0);
        end
    endtask

    task automatic run_script();
        for (int i = 0; i < q_ss.size(); i++) begin
            @(negedge clk);
            SS_n = q_ss[i]; MOSI = q_mosi[i]; tx_valid = q_txv[i]; tx_data = q_txd[i];
            @(posedge clk);
            #1;
            chk($sformatf("rx_valid@%0d", i),  rx_valid,  e_rxv[i]);
            chk($sformatf("frame_err@%0d", i), frame_err, e_err[i]);
            chk($sformatf("MISO@%0d", i),      MISO,      e_miso[i]);
            chk($sformatf("rx_data@%0d", i),   rx_data,   e_rxd[i]);
        end
        q_ss.delete(); q_mosi.delete(); q_txv.delete(); q_txd.delete();
        e_rxv.delete(); e_err.delete(); e_miso.delete(); e_rxd.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rx_valid"},  rx_valid,  0);
        chk({tag, ".frame_err"}, frame_err, 0);
        chk({tag, ".MISO"},      MISO,      0);
        chk({tag, ".rx_data"},   rx_data,   0);
    endtask

    initial begin
        int r, a, aj;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        model_reset();
        #1;
        check_all_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single write, then a two-frame burst
        desel();
        frame(2'b00, 8'hA5, FW, 0); desel();
        frame(2'b00, 8'h03, FW, 0);
        frame(2'b01, 8'hF0, FW, 0); desel();
        // read address, read data with C3 returned 3 cycles later, then a read must be an address again
        frame(2'b10, 8'h07, FW, 0);
        frame(2'b11, 8'h00, FW, 0);
        xmit(2, 8'hC3, 0);
        frame(2'b11, 8'h5A, FW, 0);
        frame(2'b00, 8'h11, FW, 0); desel();
        // write aborted after 5 bits
        frame(2'b00, 8'hFF, 5, 1); desel();
        // leave rd_addr_seen set, then reset in the middle of a write
        frame(2'b10, 8'h21, FW, 0);
        frame(2'b01, 8'h99, 4, 0);
        run_script();

        #2;
        rst = 1'b1; SS_n = 1'b1; tx_valid = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // first read frame after reset is an address frame; tx_valid there is ignored
        desel(); desel();
        frame(2'b11, 8'h3C, FW, 0);
        frame(2'b00, 8'h42, FW, 0); desel();
        run_script();

        repeat (60) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                desel();
            end else begin
                frame(2'($urandom), rbyte(),
                      ($urandom_range(0, 99) < 15) ? $urandom_range(1, FW - 1) : FW, 1);
                if (m_pend) begin
                    a  = $urandom_range(0, 99);
                    aj = (a < 10) ? $urandom_range(1, DW) : ((a < 15) ? -1 : 0);
                    xmit($urandom_range(0, 4), rbyte(), aj);
                end
            end
        end
        desel();
        run_script();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
